// File: rtl/apb_master_arb.sv
// apb_master_arb: shares one APB bus between N_REQ requesters.
// The arbiter is round-robin. The FSM sequences the SETUP and ACCESS phases and
// returns read data and error status for each transfer.
// Optional feature: define APB_TIMEOUT_EN to force completion with an error
// when a slave keeps pready low for TIMEOUT ACCESS cycles.
module apb_master_arb #(
   parameter int N_REQ   = 4,
   parameter int AW      = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                reset_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    req_write,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*32-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_err,
   output logic [AW-1:0]       paddr,
   output logic                pwrite,
   output logic                psel,
   output logic                penable,
   output logic [31:0]         pwdata,
   input  logic [31:0]         prdata,
   input  logic                pready,
   input  logic                pslverr
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Reject parameter values the design is not built for.
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("apb_master_arb: N_REQ must be in 2..8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("apb_master_arb: TIMEOUT must be in 2..255");
   end

   state_t              state_q, state_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [AW-1:0]       paddr_q, paddr_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic                pwrite_q, pwrite_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;

   logic [AW-1:0]       addr_arr  [N_REQ];
   logic [31:0]         wdata_arr [N_REQ];

   logic                pick_found;
   logic [PW-1:0]       pick_idx;
   logic                timeout_hit;
   logic                complete;

   // Split the flat requester buses into one entry per requester.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*AW +: AW];
      assign wdata_arr[g] = req_wdata[g*32 +: 32];
   end

   // Round-robin pick: the first active request at or after the pointer, wrapping around.
   always_comb begin
      int            cand_int;
      logic [PW-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_int   = 0;
      cand       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_int = int'(rr_ptr_q) + i;
         if (cand_int >= N_REQ) begin
            cand_int = cand_int - N_REQ;
         end
         cand = PW'(cand_int);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;

   // Count ACCESS cycles that have no pready. The count restarts in every SETUP phase.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_SETUP) begin
         tmo_cnt_d = '0;
      end else if (state_q == ST_ACCESS && !pready && tmo_cnt_q != 8'hFF) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
   end

   // Register for the wait-limit counter.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign timeout_hit = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == TMO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   assign complete = (state_q == ST_ACCESS) && (pready || timeout_hit);

   // Next-state logic for the FSM, the bus-owner registers and the APB outputs.
   always_comb begin
      int nxt_int;
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      nxt_int   = 0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               owner_d   = pick_idx;
               gnt_d     = N_REQ'(1) << pick_idx;
               paddr_d   = addr_arr[pick_idx];
               pwdata_d  = wdata_arr[pick_idx];
               pwrite_d  = req_write[pick_idx];
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (complete) begin
               nxt_int = int'(owner_q) + 1;
               if (nxt_int >= N_REQ) begin
                  nxt_int = 0;
               end
               rr_ptr_d  = PW'(nxt_int);
               gnt_d     = '0;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            gnt_d     = '0;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // FSM and registered bus outputs. Reset drops the bus at once.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
      end
   end

   // The completion response is combinational, so done arrives in the same cycle as pready.
   always_comb begin
      done      = complete ? gnt_q : '0;
      rsp_err   = complete && (timeout_hit || pslverr);
      rsp_rdata = (complete && !pwrite_q && !timeout_hit) ? prdata : 32'd0;
   end

   assign gnt     = gnt_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign pwrite  = pwrite_q;
   assign psel    = psel_q;
   assign penable = penable_q;

endmodule
